// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and MEM-stage data (D) requesters.
// Define ARB_RR_EN for round-robin tie-breaking; the default build gives D fixed priority over I.
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRData,
    output logic          IReady,
    output logic          IStall,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic [DW-1:0] DRData,
    output logic          DReady,
    output logic          DStall,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          gnt_d_reg;
    logic          grant_d;

`ifdef ARB_RR_EN
    // Owner of the most recent grant; starts at I so D wins the first tie.
    logic last_d_reg;

    always_comb begin
        grant_d = DReq & (~IReq | ~last_d_reg);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE && (IReq || DReq)) begin
            last_d_reg <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = DReq;
    end
`endif

    // Stalls see the registered Ready so a held request drops its stall in the Ready cycle.
    assign IStall = IReq & ~IReady;
    assign DStall = DReq & ~DReady;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            gnt_d_reg <= 1'b0;
            MemEn     <= 1'b0;
            MemWe     <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            IRData    <= '0;
            DRData    <= '0;
            IReady    <= 1'b0;
            DReady    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    IReady <= 1'b0;
                    DReady <= 1'b0;
                    if (IReq || DReq) begin
                        state_reg <= ACCESS;
                        cnt_reg   <= CW'(LATENCY - 1);
                        gnt_d_reg <= grant_d;
                        MemEn     <= 1'b1;
                        if (grant_d) begin
                            MemAddr  <= DAddr;
                            MemWe    <= DWe;
                            MemWData <= DWData;
                        end else begin
                            // Fetches are always reads; MemWData keeps its last value.
                            MemAddr <= IAddr;
                            MemWe   <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= DONE;
                        MemEn     <= 1'b0;
                        if (gnt_d_reg) begin
                            DReady <= 1'b1;
                            if (!MemWe) begin
                                DRData <= MemRData;
                            end
                        end else begin
                            IReady <= 1'b1;
                            IRData <= MemRData;
                        end
                    end
                end

                DONE: begin
                    // Always pass through IDLE so a still-held request is not served twice.
                    IReady    <= 1'b0;
                    DReady    <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    MemEn     <= 1'b0;
                    IReady    <= 1'b0;
                    DReady    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 instance plus a LATENCY=1 instance.
// Grant-order expectations follow ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;

    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, i_stall, d_ready, d_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        i_req1;
    logic [31:0] i_addr1;
    logic [31:0] i_rdata1, d_rdata1;
    logic        i_ready1, i_stall1, d_ready1, d_stall1;
    logic        mem_en1, mem_we1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    int tests;
    int errors;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'hE3A0_0001;
            32'h0000_0200: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign mem_rdata  = mem_en  ? mem_model(mem_addr)  : 32'h0;
    assign mem_rdata1 = mem_en1 ? mem_model(mem_addr1) : 32'h0;

    mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut (
        .CLK(clk), .Reset(rst_n),
        .IReq(i_req), .IAddr(i_addr), .IRData(i_rdata), .IReady(i_ready), .IStall(i_stall),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWData(d_wdata),
        .DRData(d_rdata), .DReady(d_ready), .DStall(d_stall),
        .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
        .MemRData(mem_rdata)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
        .CLK(clk), .Reset(rst_n),
        .IReq(i_req1), .IAddr(i_addr1), .IRData(i_rdata1), .IReady(i_ready1), .IStall(i_stall1),
        .DReq(1'b0), .DWe(1'b0), .DAddr(32'h0), .DWData(32'h0),
        .DRData(d_rdata1), .DReady(d_ready1), .DStall(d_stall1),
        .MemEn(mem_en1), .MemWe(mem_we1), .MemAddr(mem_addr1), .MemWData(mem_wdata1),
        .MemRData(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int rdy_at, d_at, i_at, en_cnt, stall_cnt, ng;
        logic [31:0] addr_at5;
        logic prev_en;
        int grants[4];
        int exp_grants[4];

        tests = 0; errors = 0;
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0;

        // Reset state
        #2;
        check("rst_men", 32'(mem_en), 32'h0);
        check("rst_iready", 32'(i_ready), 32'h0);
        check("rst_dready", 32'(d_ready), 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_irdata", i_rdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single I read
        i_req = 1; i_addr = 32'h10;
        #1 check("t1_istall_pre", 32'(i_stall), 32'h1);
        rdy_at = 0; en_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("t1_maddr", mem_addr, 32'h10);
                check("t1_mwe", 32'(mem_we), 32'h0);
            end
            if (mem_en) en_cnt++;
            if (i_ready) begin rdy_at = n; break; end
            check("t1_istall", 32'(i_stall), 32'h1);
        end
        check("t1_ready_at", 32'(rdy_at), 32'd3);
        check("t1_men_cycles", 32'(en_cnt), 32'd2);
        check("t1_irdata", i_rdata, 32'hE3A0_0001);
        check("t1_istall_rdy", 32'(i_stall), 32'h0);
        i_req = 0;
        @(negedge clk);
        check("t1_ready_pulse", 32'(i_ready), 32'h0);
        $display("[TB] txn1 I read 0x10 ready_at=%0d data=%h", rdy_at, i_rdata);
        @(negedge clk);

        // 2: simultaneous I and D reads, D first
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h200;
        #1;
        d_at = 0; i_at = 0; stall_cnt = (i_stall ? 1 : 0); addr_at5 = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) check("t2_maddr_d", mem_addr, 32'h200);
            if (n == 5) addr_at5 = mem_addr;
            if (i_stall) stall_cnt++;
            if (d_ready) begin
                d_at = n; d_req = 0;
                check("t2_irdata_hold", i_rdata, 32'hE3A0_0001);
            end
            if (i_ready) begin i_at = n; i_req = 0; break; end
        end
        check("t2_d_at", 32'(d_at), 32'd3);
        check("t2_i_at", 32'(i_at), 32'd7);
        check("t2_maddr_i", addr_at5, 32'h80);
        check("t2_drdata", d_rdata, 32'h1234_5678);
        check("t2_irdata", i_rdata, 32'hA5A5_0080);
        check("t2_istall_cycles", 32'(stall_cnt), 32'd7);
        $display("[TB] txn2 D 0x200 ready_at=%0d, I 0x80 ready_at=%0d", d_at, i_at);
        @(negedge clk); @(negedge clk);

        // 3: D write, fields changed mid-access
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        rdy_at = 0; en_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("t3_mwe", 32'(mem_we), 32'h1);
                check("t3_maddr", mem_addr, 32'h40);
                d_wdata = 32'h0; d_addr = 32'h44;
            end
            if (n == 2) begin
                check("t3_mwdata_latched", mem_wdata, 32'hDEAD_BEEF);
                check("t3_mwe2", 32'(mem_we), 32'h1);
            end
            if (mem_en) en_cnt++;
            if (d_ready) begin rdy_at = n; break; end
        end
        check("t3_ready_at", 32'(rdy_at), 32'd3);
        check("t3_men_cycles", 32'(en_cnt), 32'd2);
        check("t3_drdata_hold", d_rdata, 32'h1234_5678);
        d_req = 0; d_we = 0;
        $display("[TB] txn3 D write 0x40 ready_at=%0d", rdy_at);
        @(negedge clk); @(negedge clk);

        // 4: reset during first ACCESS cycle, request held throughout
        i_req = 1; i_addr = 32'h10;
        @(negedge clk);
        check("t4_men_before", 32'(mem_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t4_men_async", 32'(mem_en), 32'h0);
        check("t4_maddr_zero", mem_addr, 32'h0);
        check("t4_irdata_zero", i_rdata, 32'h0);
        check("t4_drdata_zero", d_rdata, 32'h0);
        @(negedge clk);
        check("t4_no_ready", 32'(i_ready), 32'h0);
        rst_n = 1'b1;
        rdy_at = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (i_ready) begin rdy_at = n; break; end
        end
        check("t4_regrant_at", 32'(rdy_at), 32'd3);
        check("t4_irdata", i_rdata, 32'hE3A0_0001);
        i_req = 0;
        $display("[TB] txn4 reset mid-access, regrant ready_at=%0d", rdy_at);
        @(negedge clk); @(negedge clk);

        // 5: both requesters continuously asserted
`ifdef ARB_RR_EN
        exp_grants = '{1, 0, 1, 0};
`else
        exp_grants = '{1, 1, 1, 1};
`endif
        grants = '{2, 2, 2, 2};
        i_req = 1; i_addr = 32'h90; d_req = 1; d_we = 0; d_addr = 32'h300;
        ng = 0; prev_en = mem_en;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (mem_en && !prev_en) begin
                grants[ng] = (mem_addr == 32'h300) ? 1 : 0;
                ng++;
            end
            prev_en = mem_en;
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("t5_grant%0d", g), 32'(grants[g]), 32'(exp_grants[g]));
        end
        i_req = 0; d_req = 0;
        $display("[TB] txn5 grant order (1=D) %0d %0d %0d %0d", grants[0], grants[1], grants[2], grants[3]);
        repeat (8) @(negedge clk);

        // 6: LATENCY=1 single I read
        i_req1 = 1; i_addr1 = 32'h10;
        rdy_at = 0; en_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) check("t6_maddr", mem_addr1, 32'h10);
            if (mem_en1) en_cnt++;
            if (i_ready1) begin rdy_at = n; break; end
        end
        check("t6_ready_at", 32'(rdy_at), 32'd2);
        check("t6_men_cycles", 32'(en_cnt), 32'd1);
        check("t6_irdata", i_rdata1, 32'hE3A0_0001);
        i_req1 = 0;
        $display("[TB] txn6 LATENCY=1 I read ready_at=%0d", rdy_at);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
